recompute_scheduler: RTL and testbench
======================================

Name: recompute_scheduler

Overview:
- Next-generation scheduler for the recompute-unit (RU) BISR path in the systolic array.
- Snapshots the self-test pass/fail matrix and scans it in raster order. Binds each faulty PE to a free RU slot, then issues a handshaked sweep of accumulation indices so each RU recomputes its PE's dot product.
- Adds to the previous controller: parametrised sweep depth, a ready/valid step handshake, fault counting, overflow reporting, a clean start/done protocol and asynchronous active-low reset.

Parameters:
- ROWS, 4, PE rows in the array.
- COLS, 4, PE columns in the array.
- NUM_RU, 4, number of recompute units (slots), 1..ROWS*COLS.
- K_DEPTH, 4, accumulation steps per recompute; data-column index runs 0..K_DEPTH-1.
- RW/CW/KW/FW, derived: $clog2 of ROWS, COLS, K_DEPTH and ROWS*COLS+1 respectively, minimum 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a scheduling run; sampled only in IDLE.
- stw_pass_map  in  ROWS*COLS  self-test result; bit r*COLS+c =1 means PE(r,c) passed, 0 means faulty.
- step_ready  in  1  RU array accepts the current step.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- overflow  out  1  faults exceeded NUM_RU; sticky until next accepted start.
- fault_count  out  FW  total faulty PEs found in the snapshot.
- ru_valid  out  NUM_RU  slot i is active and presenting a step.
- ru_row  out  NUM_RU*RW  faulty row bound to slot i (slice i).
- ru_col  out  NUM_RU*CW  faulty column bound to slot i.
- ru_k  out  KW  current accumulation index, common to all slots.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE and slot table is cleared, regardless of current state.
- IDLE:
  - start=1 snapshots stw_pass_map.
  - Clears fault_count, overflow and slots; scan pointer p=0.
  - Next state is SCAN.
- SCAN:
  - Examines one PE per cycle, p = 0..ROWS*COLS-1 (row-major).
  - A faulty PE increments fault_count.
  - If a slot is free, the PE is written into the lowest free slot. Otherwise overflow is set and the PE is not scheduled.
  - Scan takes exactly ROWS*COLS cycles.
  - At end of scan: go to ISSUE if at least one slot is filled, else go to DONE.
- ISSUE:
  - ru_valid[i]=1 for each filled slot; ru_k starts at 0.
  - A step transfers in any cycle where step_ready=1. On transfer, ru_k increments.
  - With step_ready=0, ru_k, ru_row and ru_col hold.
  - Transfer of ru_k=K_DEPTH-1 leads to DONE, and ru_valid drops to 0 in the same edge.
- DONE: done=1 for one cycle, then IDLE. Slot contents, fault_count and overflow remain readable.
- busy is combinationally derived from state (state!=IDLE).
- start while busy is ignored; start in the DONE cycle is also ignored.
- stw_pass_map changes after the snapshot have no effect on the run.
- fault_count never wraps; FW covers ROWS*COLS.
- Latency, no backpressure, F>0 faults: start edge to done = 1 + ROWS*COLS + K_DEPTH cycles. With F=0: 1 + ROWS*COLS.

Optional Feature:
- Macro: RECOMPUTE_MULTIPASS_EN.
- Defined:
  - When ISSUE completes with unscheduled faults remaining, the slot table is cleared and SCAN resumes at p+1 (the PE after the last one scanned into a full table), filling the next batch.
  - Repeats until the map is exhausted. done pulses once, after the final batch.
  - overflow stays 0; fault_count counts each PE exactly once.
- Undefined: single batch only; excess faults set overflow and are dropped.

Test Plan:
- All PEs pass, start pulse -> busy for 17 cycles, done at cycle 17, fault_count=0, ru_valid never high, overflow=0.
- Faults at (1,2),(3,0), step_ready=1 -> slot0=(1,2), slot1=(3,0), ru_valid=4'b0011; ru_k steps 0,1,2,3 on cycles 17..20; done at cycle 21; fault_count=2.
- Same map, step_ready toggling 1,0,1,0 -> ru_k advances only on ready cycles; all fields stable while ready=0; done after 4 transfers.
- Six faults at p=0,3,5,6,9,15, macro undefined -> slots hold p=0,3,5,6 (rows/cols (0,0),(0,3),(1,1),(1,2)); overflow=1; fault_count=6.
- Same six faults, RECOMPUTE_MULTIPASS_EN defined -> batch1 ru_valid=1111, batch2 ru_valid=0011 with (2,1),(3,3); single done; overflow=0; fault_count=6.
- rst_n asserted mid-ISSUE at ru_k=2 -> all outputs 0 immediately, FSM in IDLE; a fresh start then runs normally from scan p=0.

Source files
------------

// File: rtl/recompute_scheduler.sv
// Recompute-unit scheduler: snapshots the PE pass/fail map, binds faulty PEs to RU slots
// and sweeps accumulation indices. Define RECOMPUTE_MULTIPASS_EN to schedule excess faults in batches.
module recompute_scheduler #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int NUM_RU  = 4,
    parameter int K_DEPTH = 4,
    localparam int NPE = ROWS * COLS,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int KW  = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1,
    localparam int FW  = $clog2(NPE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NPE-1:0]       stw_pass_map,
    input  logic                 step_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [FW-1:0]        fault_count,
    output logic [NUM_RU-1:0]    ru_valid,
    output logic [NUM_RU*RW-1:0] ru_row,
    output logic [NUM_RU*CW-1:0] ru_col,
    output logic [KW-1:0]        ru_k
);
    localparam int PW = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int SW = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE, S_DONE} state_e;

    state_e                     state_q;
    logic [NPE-1:0]             snap_q;
    logic [PW-1:0]              p_q;
    logic [RW-1:0]              r_q;
    logic [CW-1:0]              c_q;
    logic [NUM_RU-1:0]          slot_vld_q;
    logic [NUM_RU-1:0][RW-1:0]  slot_row_q;
    logic [NUM_RU-1:0][CW-1:0]  slot_col_q;
    logic [KW-1:0]              k_q;
    logic [FW-1:0]              fc_q;
    logic                       ovf_q;
    logic                       done_q;
    logic                       more_q;

    logic                       fault;
    logic                       free_any;
    logic                       scan_last;
    logic                       batch_cut;
    logic [SW-1:0]              free_idx;
    logic [NUM_RU-1:0]          slot_vld_d;

    always_comb begin
        fault     = ~snap_q[p_q];
        free_any  = ~&slot_vld_q;
        scan_last = (p_q == PW'(NPE - 1));
        free_idx  = '0;
        for (int i = NUM_RU - 1; i >= 0; i--)
            if (!slot_vld_q[i]) free_idx = SW'(i);
        slot_vld_d = slot_vld_q;
        if (fault && free_any) slot_vld_d[free_idx] = 1'b1;
    end

`ifdef RECOMPUTE_MULTIPASS_EN
    logic rest_faulty;
    // Cut the batch as soon as the table fills, but only if faults remain past this PE.
    always_comb begin
        rest_faulty = 1'b0;
        for (int j = 0; j < NPE; j++)
            if (PW'(j) > p_q && !snap_q[j]) rest_faulty = 1'b1;
        batch_cut = fault && free_any && (&slot_vld_d) && rest_faulty;
    end
`else
    assign batch_cut = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            snap_q     <= '0;
            p_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            slot_vld_q <= '0;
            slot_row_q <= '0;
            slot_col_q <= '0;
            k_q        <= '0;
            fc_q       <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            more_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    snap_q     <= stw_pass_map;
                    fc_q       <= '0;
                    ovf_q      <= 1'b0;
                    slot_vld_q <= '0;
                    slot_row_q <= '0;
                    slot_col_q <= '0;
                    p_q        <= '0;
                    r_q        <= '0;
                    c_q        <= '0;
                    k_q        <= '0;
                    more_q     <= 1'b0;
                    state_q    <= S_SCAN;
                end
                S_SCAN: begin
                    if (fault) begin
                        fc_q <= fc_q + 1'b1;
                        if (free_any) begin
                            slot_vld_q           <= slot_vld_d;
                            slot_row_q[free_idx] <= r_q;
                            slot_col_q[free_idx] <= c_q;
                        end
`ifndef RECOMPUTE_MULTIPASS_EN
                        else ovf_q <= 1'b1;
`endif
                    end
                    p_q <= p_q + 1'b1;
                    if (c_q == CW'(COLS - 1)) begin
                        c_q <= '0;
                        r_q <= r_q + 1'b1;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                    if (scan_last || batch_cut) begin
                        more_q  <= batch_cut;
                        state_q <= (|slot_vld_d) ? S_ISSUE : S_DONE;
                        done_q  <= ~|slot_vld_d;
                        if (scan_last) begin
                            p_q <= '0;
                            r_q <= '0;
                            c_q <= '0;
                        end
                    end
                end
                S_ISSUE: if (step_ready) begin
                    if (k_q == KW'(K_DEPTH - 1)) begin
                        k_q <= '0;
                        if (more_q) begin
                            // Next batch resumes scanning from the PE after the cut point.
                            slot_vld_q <= '0;
                            slot_row_q <= '0;
                            slot_col_q <= '0;
                            more_q     <= 1'b0;
                            state_q    <= S_SCAN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign fault_count = fc_q;
    assign ru_valid    = (state_q == S_ISSUE) ? slot_vld_q : '0;
    assign ru_row      = slot_row_q;
    assign ru_col      = slot_col_q;
    assign ru_k        = k_q;

endmodule

// File: tb/tb_recompute_scheduler.sv
// Randomized bench for recompute_scheduler: a per-run cycle timeline is derived from the
// scheduling rules and compared to the DUT every cycle, plus literal scenario expectations.
module tb_recompute_scheduler;
    localparam int ROWS = 4, COLS = 4, NUM_RU = 4, K_DEPTH = 4;
    localparam int NPE = 16, RW = 2, CW = 2, KW = 2, FW = 5, MAXC = 256;
`ifdef RECOMPUTE_MULTIPASS_EN
    localparam bit MP = 1'b1;
`else
    localparam bit MP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [NPE-1:0]       stw_pass_map = '1;
    logic                 step_ready = 1'b0;
    logic                 busy, done, overflow;
    logic [FW-1:0]        fault_count;
    logic [NUM_RU-1:0]    ru_valid;
    logic [NUM_RU*RW-1:0] ru_row;
    logic [NUM_RU*CW-1:0] ru_col;
    logic [KW-1:0]        ru_k;

    recompute_scheduler #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU), .K_DEPTH(K_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stw_pass_map(stw_pass_map),
        .step_ready(step_ready), .busy(busy), .done(done), .overflow(overflow),
        .fault_count(fault_count), .ru_valid(ru_valid), .ru_row(ru_row), .ru_col(ru_col),
        .ru_k(ru_k)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic                 e_busy[MAXC], e_done[MAXC], e_ov[MAXC];
    logic [NUM_RU-1:0]    e_vld[MAXC];
    logic [KW-1:0]        e_k[MAXC];
    logic [FW-1:0]        e_fc[MAXC];
    logic [NUM_RU*RW-1:0] e_row[MAXC];
    logic [NUM_RU*CW-1:0] e_col[MAXC];
    int                   e_len;
    bit                   rdy[MAXC];
    logic [NUM_RU-1:0]    o_vld[MAXC];
    logic [KW-1:0]        o_k[MAXC];
    int                   m_row[NUM_RU], m_col[NUM_RU];
    bit                   m_sv[NUM_RU];

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic emit(input int t, input bit b, input bit d, input bit iss, input int k,
                        input int fc, input bit ov);
        logic [NUM_RU*RW-1:0] rp;
        logic [NUM_RU*CW-1:0] cp;
        logic [NUM_RU-1:0]    v;
        if (t >= MAXC) return;
        rp = '0; cp = '0; v = '0;
        for (int i = 0; i < NUM_RU; i++) begin
            rp[i*RW +: RW] = RW'(m_row[i]);
            cp[i*CW +: CW] = CW'(m_col[i]);
            v[i] = iss & m_sv[i];
        end
        e_busy[t] = b; e_done[t] = d; e_vld[t] = v; e_k[t] = KW'(k);
        e_fc[t] = FW'(fc); e_ov[t] = ov; e_row[t] = rp; e_col[t] = cp;
    endtask

    function automatic bit faulty_after(input logic [NPE-1:0] snap, input int p);
        for (int j = p + 1; j < NPE; j++) if (!snap[j]) return 1'b1;
        return 1'b0;
    endfunction

    // Expected timeline: cycle t is the clock period after the t-th edge following start.
    task automatic build(input logic [NPE-1:0] snap);
        int t, p, fc, n, k;
        bit ov, cut;
        t = 1; p = 0; fc = 0; ov = 1'b0;
        do begin
            for (int i = 0; i < NUM_RU; i++) begin m_sv[i] = 0; m_row[i] = 0; m_col[i] = 0; end
            n = 0; cut = 1'b0;
            while (p < NPE && !cut) begin
                emit(t, 1, 0, 0, 0, fc, ov); t++;
                if (!snap[p]) begin
                    fc++;
                    if (n < NUM_RU) begin
                        m_sv[n] = 1; m_row[n] = p / COLS; m_col[n] = p % COLS; n++;
                        if (MP && n == NUM_RU && faulty_after(snap, p)) cut = 1'b1;
                    end else ov = 1'b1;
                end
                p++;
            end
            if (n > 0) begin
                k = 0;
                while (k < K_DEPTH) begin
                    emit(t, 1, 0, 1, k, fc, ov);
                    if (t >= MAXC - 3 || rdy[t]) k++;
                    t++;
                end
            end
        end while (MP && p < NPE);
        emit(t, 1, 1, 0, 0, fc, ov);
        e_len = t;
        emit(t + 1, 0, 0, 0, 0, fc, ov);
    endtask

    task automatic run(input logic [NPE-1:0] snap, input int rmode, input bit noise,
                       output int done_at, output int n_done);
        for (int t = 0; t < MAXC; t++)
            rdy[t] = (rmode == 0) ? 1'b1 : (rmode == 1) ? bit'(t % 2) :
                     ((t >= 100) || ($urandom_range(3) != 0));
        build(snap);
        done_at = -1; n_done = 0;
        if (e_len > MAXC - 2) begin
            chk("model_len_bound", 0, 32'(e_len), 32'(MAXC - 2));
            e_len = MAXC - 2;
        end
        @(negedge clk);
        stw_pass_map = snap; start = 1'b1; step_ready = rdy[0];
        @(negedge clk);
        for (int t = 1; t <= e_len + 1; t++) begin
            start = (noise && t <= e_len) ? ((t == e_len) ? 1'b1 : 1'($urandom_range(1))) : 1'b0;
            stw_pass_map = NPE'($urandom);
            step_ready = rdy[t];
            chk("busy", t, 32'(busy), 32'(e_busy[t]));
            chk("done", t, 32'(done), 32'(e_done[t]));
            chk("overflow", t, 32'(overflow), 32'(e_ov[t]));
            chk("fault_count", t, 32'(fault_count), 32'(e_fc[t]));
            chk("ru_valid", t, 32'(ru_valid), 32'(e_vld[t]));
            chk("ru_k", t, 32'(ru_k), 32'(e_k[t]));
            chk("ru_row", t, 32'(ru_row), 32'(e_row[t]));
            chk("ru_col", t, 32'(ru_col), 32'(e_col[t]));
            o_vld[t] = ru_valid; o_k[t] = ru_k;
            if (done) begin n_done++; if (done_at < 0) done_at = t; end
            @(negedge clk);
        end
        start = 1'b0; step_ready = 1'b0;
        chk("idle_after_done", e_len + 2, 32'(busy), 32'(0));
    endtask

    initial begin
        int da, nd;
        logic [NPE-1:0] s;
        logic [NUM_RU-1:0] acc;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_busy", 0, 32'(busy), 32'(0));
        chk("rst_outs", 0, 32'({done, overflow, fault_count, ru_valid, ru_k}), 32'(0));
        chk("rst_slots", 0, 32'({ru_row, ru_col}), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // all PEs pass
        run('1, 0, 1'b0, da, nd);
        chk("t1_done_at", 0, 32'(da), 32'(17));
        chk("t1_model_len", 0, 32'(e_len), 32'(17));
        chk("t1_fc", 0, 32'(fault_count), 32'(0));
        chk("t1_ovf", 0, 32'(overflow), 32'(0));
        acc = '0;
        for (int t = 1; t <= 17; t++) acc |= o_vld[t];
        chk("t1_vld_never", 0, 32'(acc), 32'(0));

        // faults at (1,2) and (3,0)
        s = '1; s[6] = 1'b0; s[12] = 1'b0;
        run(s, 0, 1'b1, da, nd);
        chk("t2_done_at", 0, 32'(da), 32'(21));
        chk("t2_ndone", 0, 32'(nd), 32'(1));
        chk("t2_fc", 0, 32'(fault_count), 32'(2));
        chk("t2_row", 0, 32'(ru_row), 32'h0D);
        chk("t2_col", 0, 32'(ru_col), 32'h02);
        chk("t2_vld", 17, 32'(o_vld[17]), 32'h3);
        for (int t = 17; t <= 20; t++) chk("t2_k", t, 32'(o_k[t]), 32'(t - 17));

        // same map, ready toggling
        run(s, 1, 1'b0, da, nd);
        chk("t3_done_at", 0, 32'(da), 32'(24));
        chk("t3_k18", 18, 32'(o_k[18]), 32'(1));
        chk("t3_k19", 19, 32'(o_k[19]), 32'(1));
        chk("t3_k20", 20, 32'(o_k[20]), 32'(2));

        // six faults at p=0,3,5,6,9,15
        s = '1; s[0] = 0; s[3] = 0; s[5] = 0; s[6] = 0; s[9] = 0; s[15] = 0;
        run(s, 0, 1'b1, da, nd);
        chk("t4_fc", 0, 32'(fault_count), 32'(6));
        chk("t4_ndone", 0, 32'(nd), 32'(1));
`ifdef RECOMPUTE_MULTIPASS_EN
        chk("t4_done_at", 0, 32'(da), 32'(25));
        chk("t4_ovf", 0, 32'(overflow), 32'(0));
        chk("t4_row", 0, 32'(ru_row), 32'h0E);
        chk("t4_col", 0, 32'(ru_col), 32'h0D);
        chk("t4_vld_b1", 8, 32'(o_vld[8]), 32'hF);
        chk("t4_vld_b2", 21, 32'(o_vld[21]), 32'h3);
`else
        chk("t4_done_at", 0, 32'(da), 32'(21));
        chk("t4_ovf", 0, 32'(overflow), 32'(1));
        chk("t4_row", 0, 32'(ru_row), 32'h50);
        chk("t4_col", 0, 32'(ru_col), 32'h9C);
        chk("t4_vld", 17, 32'(o_vld[17]), 32'hF);
`endif

        // reset mid-ISSUE at ru_k=2
        s = '1; s[6] = 1'b0; s[12] = 1'b0;
        @(negedge clk);
        stw_pass_map = s; start = 1'b1; step_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        chk("t5_k_before", 19, 32'(ru_k), 32'(2));
        chk("t5_vld_before", 19, 32'(ru_valid), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 19, 32'(busy), 32'(0));
        chk("t5_rst_outs", 19, 32'({done, overflow, fault_count, ru_valid, ru_k}), 32'(0));
        chk("t5_rst_slots", 19, 32'({ru_row, ru_col}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1; step_ready = 1'b0;
        run(s, 0, 1'b0, da, nd);
        chk("t5_rerun_done_at", 0, 32'(da), 32'(21));
        chk("t5_rerun_fc", 0, 32'(fault_count), 32'(2));

        // randomized maps with random backpressure and start noise
        for (int r = 0; r < 10; r++) begin
            s = NPE'($urandom);
            if (r < 5) s = s | NPE'($urandom);
            run(s, 2, 1'b1, da, nd);
            chk("rnd_ndone", r, 32'(nd), 32'(1));
            chk("rnd_fc", r, 32'(fault_count), 32'($countones(~s)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
